// File: rtl/mfp_adc_max10_avg.sv
// Oversampling averager for MAX10 ADC responses: per-channel sums over 2^k packets, emitted as one Avalon-ST packet.
// Latency: first averaged beat one cycle after the completing EOP; no backpressure, one beat per cycle, drops a round on overrun.
module mfp_adc_max10_avg #(
    parameter int DATA_WIDTH = 12,
    parameter int MAX_LOG2   = 7
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [2:0]            avg_log2,
    input  logic                  in_valid,
    input  logic [4:0]            in_channel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  out_valid,
    output logic [4:0]            out_channel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int ACC_W = DATA_WIDTH + MAX_LOG2;
    localparam logic [MAX_LOG2:0] ONE = {{MAX_LOG2{1'b0}}, 1'b1};

    logic [ACC_W-1:0]      acc      [32];
    logic [DATA_WIDTH-1:0] snap     [32];
    logic [ACC_W-1:0]      sum_new  [32];
    logic [DATA_WIDTH-1:0] snap_new [32];
    logic [31:0]           hit;
    logic [31:0]           pending;
    logic [MAX_LOG2-1:0]   cnt;
    logic [2:0]            k;
    logic                  emitting;

    logic [2:0]            k_eff;
    logic [MAX_LOG2:0]     len_m1;
    logic                  complete;
    logic                  multi;
    logic                  accept;
    logic [31:0]           hit_next;
    logic [4:0]            low;
    logic [31:0]           low_bit;
    logic                  unused_sop;

    assign unused_sop = in_sop;
    assign busy       = |pending;

    always_comb begin
        // the shift is taken from avg_log2 only on the first valid beat of a round
        k_eff = k;
        if (hit == '0) begin
            k_eff = (avg_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : avg_log2;
        end
        len_m1   = (ONE << k_eff) - ONE;
        complete = in_valid & in_eop & ({1'b0, cnt} == len_m1);
        multi    = |(pending & (pending - 32'd1));
        accept   = complete & ~multi;
        hit_next = hit | (32'd1 << in_channel);
        low = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pending[i]) begin
                low = i[4:0];
            end
        end
        low_bit = 32'd1 << low;
        for (int c = 0; c < 32; c++) begin
            sum_new[c] = acc[c];
            if (in_valid && (in_channel == c[4:0])) begin
                sum_new[c] = acc[c] + {{MAX_LOG2{1'b0}}, in_data};
            end
            snap_new[c] = DATA_WIDTH'(sum_new[c] >> k_eff);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < 32; c++) begin
                acc[c]  <= '0;
                snap[c] <= '0;
            end
            hit         <= '0;
            pending     <= '0;
            cnt         <= '0;
            k           <= '0;
            emitting    <= 1'b0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (in_valid) begin
                if (hit == '0) begin
                    k <= k_eff;
                end
                if (complete) begin
                    for (int c = 0; c < 32; c++) begin
                        acc[c] <= '0;
                        if (accept) begin
                            snap[c] <= snap_new[c];
                        end
                    end
                    hit <= '0;
                    cnt <= '0;
                end else begin
                    acc[in_channel] <= sum_new[in_channel];
                    hit             <= hit_next;
                    if (in_eop) begin
                        cnt <= cnt + MAX_LOG2'(1);
                    end
                end
            end

            // snap is read before this edge's possible refill, so a legal back-to-back round is safe
            if (pending != '0) begin
                out_valid   <= 1'b1;
                out_channel <= low;
                out_data    <= snap[low];
                out_sop     <= ~emitting;
                out_eop     <= ~multi;
                emitting    <= multi;
            end else begin
                out_valid   <= 1'b0;
                out_channel <= '0;
                out_data    <= '0;
                out_sop     <= 1'b0;
                out_eop     <= 1'b0;
                emitting    <= 1'b0;
            end

            if (accept) begin
                pending <= hit_next;
            end else if (pending != '0) begin
                pending <= pending & ~low_bit;
            end

            if (complete && multi) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mfp_adc_max10_avg.sv
// Directed bench for mfp_adc_max10_avg with a per-edge schedule model of the averaged output stream.
module tb_mfp_adc_max10_avg;

    localparam int NE = 4096;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  avg_log2;
    logic        in_valid;
    logic [4:0]  in_channel;
    logic [11:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic        out_valid;
    logic [4:0]  out_channel;
    logic [11:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;

    always #5 CLK = ~CLK;

    mfp_adc_max10_avg #(.DATA_WIDTH(12), .MAX_LOG2(7)) dut (
        .CLK(CLK), .RESET(RESET), .avg_log2(avg_log2),
        .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    int checks = 0;
    int passes = 0;
    int edge_n = 0;

    // expected state after each clock edge
    bit exp_v[NE];
    int exp_ch[NE];
    int exp_d[NE];
    bit exp_sop[NE];
    bit exp_eop[NE];
    bit exp_busy[NE];
    bit exp_ovr[NE];

    int sum[32];
    bit mhit[32];
    int mcnt = 0;
    int mk = 0;
    bit mopen = 0;
    int last_edge = 0;
    bit movr = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
    endtask

    // Applies the current inputs to the model as they will be seen at edge n.
    task automatic model_step(input int n);
        int c;
        int j;
        bit set_ovr;
        set_ovr = 0;
        if (RESET) begin
            for (int e = n; e < NE; e++) begin
                exp_v[e] = 0; exp_ch[e] = 0; exp_d[e] = 0; exp_sop[e] = 0;
                exp_eop[e] = 0; exp_busy[e] = 0; exp_ovr[e] = 0;
            end
            for (int i = 0; i < 32; i++) begin
                sum[i] = 0; mhit[i] = 0;
            end
            mcnt = 0; mk = 0; mopen = 0; last_edge = n; movr = 0;
            return;
        end
        if (in_valid) begin
            c = int'(in_channel);
            if (!mopen) begin
                mk = int'(avg_log2);
                mopen = 1;
            end
            sum[c] += int'(in_data);
            mhit[c] = 1;
            if (in_eop) begin
                if (mcnt == (1 << mk) - 1) begin
                    if (last_edge > n) begin
                        set_ovr = 1;
                    end else begin
                        j = 0;
                        for (int ch = 0; ch < 32; ch++) begin
                            if (mhit[ch]) begin
                                exp_v[n+1+j]   = 1;
                                exp_ch[n+1+j]  = ch;
                                exp_d[n+1+j]   = (sum[ch] >> mk) & 4095;
                                exp_sop[n+1+j] = (j == 0);
                                j++;
                            end
                        end
                        exp_eop[n+j] = 1;
                        for (int e = n; e < n + j; e++) exp_busy[e] = 1;
                        last_edge = n + j;
                    end
                    for (int i = 0; i < 32; i++) begin
                        sum[i] = 0; mhit[i] = 0;
                    end
                    mcnt = 0;
                    mopen = 0;
                end else begin
                    mcnt++;
                end
            end
        end
        if (set_ovr) movr = 1;
        else if (overrun_clr) movr = 0;
        exp_ovr[n] = movr;
    endtask

    always @(negedge CLK) begin
        if (edge_n > 0 && edge_n < NE) begin
            chk("out_valid", int'(out_valid), int'(exp_v[edge_n]));
            if (exp_v[edge_n]) begin
                chk("out_channel", int'(out_channel), exp_ch[edge_n]);
                chk("out_data", int'(out_data), exp_d[edge_n]);
                chk("out_sop", int'(out_sop), int'(exp_sop[edge_n]));
                chk("out_eop", int'(out_eop), int'(exp_eop[edge_n]));
            end
            chk("busy", int'(busy), int'(exp_busy[edge_n]));
            chk("overrun", int'(overrun), int'(exp_ovr[edge_n]));
        end
    end

    task automatic cyc(input bit v, input int ch, input int d, input bit sop, input bit eop,
                       input bit clr, input bit rst);
        RESET = rst; in_valid = v; in_channel = ch[4:0]; in_data = d[11:0];
        in_sop = sop; in_eop = eop; overrun_clr = clr;
        model_step(edge_n + 1);
        @(posedge CLK);
        edge_n++;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input int ch, input int d, input bit sop, input bit eop);
        cyc(1, ch, d, sop, eop, 0, 0);
    endtask

    task automatic wide_packet();
        for (int ch = 0; ch < 32; ch++) beat(ch, ch * 100 + 5, ch == 0, ch == 31);
    endtask

    initial begin
        avg_log2 = 3'd0;
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        idle(1);

        // four packets averaged into one
        avg_log2 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            beat(3, 100 + i, 1, 1);
            if (i == 2) chk("t1_no_early", int'(out_valid), 0);
        end
        chk("t1_busy", int'(busy), 1);
        chk("t1_latency", int'(out_valid), 0);
        idle(1);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_ch", int'(out_channel), 3);
        chk("t1_data", int'(out_data), 101);
        chk("t1_soeop", int'({out_sop, out_eop}), 3);
        idle(2);

        // pass-through with three channels
        avg_log2 = 3'd0;
        beat(1, 4095, 1, 0);
        beat(8, 7, 0, 0);
        beat(17, 2048, 0, 1);
        idle(1);
        chk("t2_b0", int'({out_sop, out_channel, out_data}), (1 << 17) | (1 << 12) | 4095);
        idle(1);
        chk("t2_b1", int'({out_channel, out_data}), (8 << 12) | 7);
        idle(1);
        chk("t2_b2", int'({out_eop, out_channel, out_data}), (1 << 17) | (17 << 12) | 2048);
        idle(2);

        // two packets with different channel sets
        avg_log2 = 3'd1;
        beat(0, 10, 1, 0);
        beat(2, 20, 0, 1);
        beat(2, 30, 1, 1);
        idle(1);
        chk("t3_ch0", int'(out_data), 5);
        idle(1);
        chk("t3_ch2", int'(out_data), 25);
        chk("t3_eop", int'(out_eop), 1);
        idle(2);

        // overrun while a 32-beat emission is in flight
        avg_log2 = 3'd0;
        wide_packet();
        idle(1);
        beat(9, 77, 1, 1);
        chk("t4_ovr_set", int'(overrun), 1);
        idle(36);
        chk("t4_ovr_sticky", int'(overrun), 1);
        chk("t4_idle", int'(busy), 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("t4_ovr_clr", int'(overrun), 0);
        wide_packet();
        idle(1);
        cyc(1, 9, 77, 1, 1, 1, 0);
        chk("t4_set_wins", int'(overrun), 1);
        idle(36);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // new round completing on the final out_eop beat
        beat(0, 1, 1, 0);
        beat(1, 2, 0, 1);
        idle(1);
        beat(5, 9, 1, 1);
        chk("t4_b2b_ovr", int'(overrun), 0);
        chk("t4_b2b_last", int'({out_eop, out_channel}), (1 << 5) | 1);
        idle(1);
        chk("t4_b2b_next", int'({out_sop, out_channel, out_data}), (1 << 17) | (5 << 12) | 9);
        idle(2);

        // shift change mid-round applies to the next round
        avg_log2 = 3'd2;
        beat(5, 8, 1, 1);
        beat(5, 12, 1, 1);
        avg_log2 = 3'd0;
        beat(5, 16, 1, 1);
        chk("t5_no_early", int'(busy), 0);
        beat(5, 20, 1, 1);
        idle(1);
        chk("t5_avg4", int'(out_data), 14);
        beat(5, 33, 1, 1);
        idle(1);
        chk("t5_avg1", int'(out_data), 33);
        idle(2);

        // reset during emission and with a partly accumulated round
        beat(1, 10, 1, 0);
        beat(2, 20, 0, 0);
        beat(3, 30, 0, 1);
        beat(4, 1000, 1, 0);
        chk("t6_first", int'(out_channel), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t6_outs", int'({out_valid, out_channel, out_data, out_sop, out_eop}), 0);
        chk("t6_busy", int'(busy), 0);
        beat(4, 50, 1, 0);
        beat(6, 60, 0, 1);
        idle(1);
        chk("t6_ch4", int'(out_data), 50);
        idle(1);
        chk("t6_ch6", int'(out_data), 60);
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
